cache_ctrl: RTL and testbench

//  Controller for the direct-mapped cache: sequences the valid, tag and data line RAMs.

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/cache_ctrl_sat_counter.sv | 28 ++
 rtl/cache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_ctrl_pkg : controller state type and default cache geometry   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cache_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_INDEX_LENGTH = 4;
  localparam int DEF_CACHE_LINES  = 16;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_CNT_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_MEM_REQ = 3'd3,
    ST_FILL    = 3'd4,
    ST_RESPOND = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_ctrl_sat_counter : up-counter that sticks at all-ones         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cache_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_ctrl : direct-mapped cache sequencer with refill and flush    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
  parameter int CACHE_LINES  = DEF_CACHE_LINES,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           cpu_req_i,
  input  logic [ADDR_WIDTH-1:0]          cpu_addr_i,
  output logic                           cpu_ready_o,
  output logic [DATA_WIDTH-1:0]          cpu_data_o,
  output logic                           busy_o,
  output logic [INDEX_LENGTH-1:0]        ram_index_o,
  input  logic                           ram_valid_i,
  input  logic [ADDR_WIDTH-INDEX_LENGTH-1:0] ram_tag_i,
  input  logic [DATA_WIDTH-1:0]          ram_data_i,
  output logic                           valid_we_o,
  output logic                           valid_wd_o,
  output logic                           tag_we_o,
  output logic [ADDR_WIDTH-INDEX_LENGTH-1:0] ram_tag_o,
  output logic                           data_we_o,
  output logic [DATA_WIDTH-1:0]          ram_data_o,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic                           mem_ack_i,
  input  logic [DATA_WIDTH-1:0]          mem_data_i,
  output logic [CNT_WIDTH-1:0]           hit_cnt_o,
  output logic [CNT_WIDTH-1:0]           miss_cnt_o
);

  localparam logic [INDEX_LENGTH:0] LAST_CNT = (INDEX_LENGTH+1)'(CACHE_LINES);

  state_e                  state_q;
  logic [INDEX_LENGTH:0]   flush_cnt_q;
  logic [INDEX_LENGTH-1:0] flush_idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    flush_pend_q;
  logic                    mem_req_q;
  logic                    cpu_ready_q;
  logic                    valid_we_q;
  logic                    valid_wd_q;
  logic                    fill_we_q;

  logic lookup_hit;
  logic hit_inc;
  logic miss_inc;

  assign lookup_hit = ram_valid_i && (ram_tag_i == addr_q[ADDR_WIDTH-1:INDEX_LENGTH]);
  assign hit_inc    = (state_q == ST_LOOKUP) && lookup_hit;
  assign miss_inc   = (state_q == ST_LOOKUP) && !lookup_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FLUSH;
      flush_cnt_q  <= '0;
      flush_idx_q  <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      cpu_ready_q  <= 1'b0;
      valid_we_q   <= 1'b0;
      valid_wd_q   <= 1'b0;
      fill_we_q    <= 1'b0;
    end else begin
      valid_we_q  <= 1'b0;
      valid_wd_q  <= 1'b0;
      fill_we_q   <= 1'b0;
      cpu_ready_q <= 1'b0;
      // A flush seen mid-transaction is deferred until the CPU has its data
      if (flush_i && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q == LAST_CNT) begin
            state_q <= ST_IDLE;
          end else begin
            valid_we_q  <= 1'b1;
            flush_idx_q <= flush_cnt_q[INDEX_LENGTH-1:0];
            flush_cnt_q <= flush_cnt_q + (INDEX_LENGTH+1)'(1);
          end
        end
        ST_IDLE: begin
          if (flush_i || flush_pend_q) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
          end else if (cpu_req_i) begin
            addr_q  <= cpu_addr_i;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            data_q      <= ram_data_i;
            cpu_ready_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= ST_MEM_REQ;
          end
        end
        ST_MEM_REQ: begin
          if (mem_ack_i) begin
            data_q     <= mem_data_i;
            mem_req_q  <= 1'b0;
            valid_we_q <= 1'b1;
            valid_wd_q <= 1'b1;
            fill_we_q  <= 1'b1;
            state_q    <= ST_FILL;
          end
        end
        ST_FILL: begin
          cpu_ready_q <= 1'b1;
          state_q     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_FLUSH;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign ram_index_o = (state_q == ST_FLUSH) ? flush_idx_q : addr_q[INDEX_LENGTH-1:0];
  assign valid_we_o  = valid_we_q;
  assign valid_wd_o  = valid_wd_q;
  assign tag_we_o    = fill_we_q;
  assign data_we_o   = fill_we_q;
  assign ram_tag_o   = addr_q[ADDR_WIDTH-1:INDEX_LENGTH];
  assign ram_data_o  = data_q;
  assign cpu_data_o  = data_q;
  assign cpu_ready_o = cpu_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;

  cache_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit_inc),
    .count_o (hit_cnt_o)
  );

  cache_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (miss_inc),
    .count_o (miss_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cache_ctrl : self-checking bench with line RAM and memory models |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, cpu_req_i;
  logic [15:0] cpu_addr_i;
  logic        cpu_ready_o, busy_o;
  logic [31:0] cpu_data_o;
  logic [3:0]  ram_index_o;
  logic        ram_valid_i;
  logic [11:0] ram_tag_i, ram_tag_o;
  logic [31:0] ram_data_i, ram_data_o;
  logic        valid_we_o, valid_wd_o, tag_we_o, data_we_o;
  logic        mem_req_o, mem_ack_i;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic [15:0] hit_cnt_o, miss_cnt_o;
  logic        sat_inc;
  logic [15:0] sat_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_ready_o(cpu_ready_o), .cpu_data_o(cpu_data_o), .busy_o(busy_o),
    .ram_index_o(ram_index_o), .ram_valid_i(ram_valid_i), .ram_tag_i(ram_tag_i),
    .ram_data_i(ram_data_i), .valid_we_o(valid_we_o), .valid_wd_o(valid_wd_o),
    .tag_we_o(tag_we_o), .ram_tag_o(ram_tag_o), .data_we_o(data_we_o), .ram_data_o(ram_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  cache_ctrl_sat_counter #(.WIDTH(16)) u_sat (
    .clk(clk), .rst(rst), .inc_i(sat_inc), .count_o(sat_cnt)
  );

  // Backing memory contents
  function automatic logic [31:0] memfn(input logic [15:0] a);
    if (a == 16'h0123) return 32'hDEADBEEF;
    return {a ^ 16'hC0DE, ~a};
  endfunction

  // Line RAMs: async read, write on clock; seed preloads stale "valid" lines
  logic        seed;
  logic        vram [16];
  logic [11:0] tram [16];
  logic [31:0] dram [16];
  assign ram_valid_i = vram[ram_index_o];
  assign ram_tag_i   = tram[ram_index_o];
  assign ram_data_i  = dram[ram_index_o];

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 16; i++) begin
        vram[i] <= 1'b1;
        tram[i] <= 12'h012;
        dram[i] <= 32'hBAD0_0000 + i;
      end
    end else begin
      if (valid_we_o) vram[ram_index_o] <= valid_wd_o;
      if (tag_we_o)   tram[ram_index_o] <= ram_tag_o;
      if (data_we_o)  dram[ram_index_o] <= ram_data_o;
    end
  end

  // Memory responder: ack on cycle (mem_delay+1) of an outstanding request
  int mem_delay = 0;
  int mr_cnt = 0;
  always @(negedge clk) begin
    if (mem_req_o) begin
      mr_cnt     = mr_cnt + 1;
      mem_ack_i  = (mr_cnt > mem_delay);
      mem_data_i = memfn(mem_addr_o);
    end else begin
      mr_cnt     = 0;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
    end
  end

  // Reference cache contents and counts
  bit          mv [16];
  logic [11:0] mt [16];
  int          mhits = 0;
  int          mmiss = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic check_flush_sweep(input string nm);
    int ns = 0;
    int n = 0;
    bit ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (valid_we_o) begin
        if (ram_index_o != 4'(ns) || valid_wd_o || tag_we_o || data_we_o || !busy_o) ok = 1'b0;
        ns++;
      end
      if (mem_req_o || cpu_ready_o) ok = 1'b0;
      if (!busy_o && ns > 0) break;
    end
    check({nm, "_strobes"}, 32'(ns), 32'd16);
    check({nm, "_sweep_ok"}, 32'(ok), 32'd1);
    check({nm, "_idle_after"}, 32'(busy_o), 32'd0);
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input int dly, input bit exp_hit,
                         input logic [31:0] exp_data, input int flush_at);
    int k = 0;
    int nreq = 0;
    int nfill = 0;
    int exp_k;
    bit got = 1'b0;
    bit fill_ok = 1'b1;
    bit addr_ok = 1'b1;
    bit flushed;
    logic [31:0] rdata = 'x;
    wait_idle();
    mem_delay  = dly;
    cpu_addr_i = a;
    cpu_req_i  = 1'b1;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_req_o) begin
        nreq++;
        if (mem_addr_o != a) addr_ok = 1'b0;
      end
      if (valid_we_o || tag_we_o || data_we_o) begin
        nfill++;
        if (!(valid_we_o && valid_wd_o && tag_we_o && data_we_o && ram_index_o == a[3:0] &&
              ram_tag_o == a[15:4] && ram_data_o == exp_data)) fill_ok = 1'b0;
      end
      if (cpu_ready_o) begin
        got   = 1'b1;
        rdata = cpu_data_o;
      end
      flush_i = (k == flush_at);
    end
    cpu_req_i = 1'b0;
    flush_i   = 1'b0;
    flushed   = (flush_at > 0) && (flush_at < k);
    if (exp_hit) mhits++;
    else begin
      mmiss++;
      mv[a[3:0]] = 1'b1;
      mt[a[3:0]] = a[15:4];
    end
    exp_k = exp_hit ? 2 : 4 + dly;
    check($sformatf("ready_cycle@%h", a), got ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_k));
    check($sformatf("rdata@%h", a), rdata, exp_data);
    check($sformatf("fill@%h", a), {31'd0, fill_ok} + (32'(nfill) << 1), exp_hit ? 32'd1 : 32'd3);
    check($sformatf("memreq@%h", a), {31'd0, addr_ok} + (32'(nreq) << 1),
          exp_hit ? 32'd1 : 32'(2 * (dly + 1) + 1));
    check("hit_cnt", 32'(hit_cnt_o), 32'(mhits));
    check("miss_cnt", 32'(miss_cnt_o), 32'(mmiss));
    if (flushed) check_flush_sweep("pend_flush");
  endtask

  typedef struct {
    logic [15:0] addr;
    int          dly;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h0123, 4, 1'b0, 32'hDEADBEEF};
    vt[1] = '{16'h0123, 0, 1'b1, 32'hDEADBEEF};
    vt[2] = '{16'h0223, 0, 1'b0, 32'hC2FDFDDC};
    vt[3] = '{16'h0223, 1, 1'b1, 32'hC2FDFDDC};
    vt[4] = '{16'h0123, 2, 1'b0, 32'hDEADBEEF};
    vt[5] = '{16'h0005, 0, 1'b0, 32'hC0DBFFFA};

    rst = 1'b1; seed = 1'b1; flush_i = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0; sat_inc = 1'b0;
    repeat (2) @(negedge clk);
    seed = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_strobes", {27'd0, valid_we_o, tag_we_o, data_we_o, mem_req_o, cpu_ready_o}, 32'd0);
    check("rst_counts", {hit_cnt_o, miss_cnt_o}, 32'd0);
    check("rst_data", cpu_data_o, 32'd0);
    cpu_req_i  = 1'b1;
    cpu_addr_i = 16'h0123;
    rst = 1'b0;
    check_flush_sweep("reset");
    cpu_req_i = 1'b0;

    for (int i = 0; i < 6; i++) do_read(vt[i].addr, vt[i].dly, vt[i].hit, vt[i].data, 0);

    // flush and request together in IDLE: flush wins
    wait_idle();
    flush_i = 1'b1; cpu_req_i = 1'b1; cpu_addr_i = 16'h0005;
    @(negedge clk);
    flush_i = 1'b0;
    check_flush_sweep("flush_wins");
    cpu_req_i = 1'b0;
    do_read(16'h0005, 0, 1'b0, 32'hC0DBFFFA, 0);

    // flush during MEM_REQ: refill completes, then sweep, then line 3 misses
    do_read(16'h0223, 6, 1'b0, 32'hC2FDFDDC, 3);
    do_read(16'h0223, 0, 1'b0, 32'hC2FDFDDC, 0);

    for (int r = 0; r < 60; r++) begin
      logic [15:0] a;
      int fl;
      a  = {12'h010 + 12'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
      fl = ($urandom_range(0, 7) == 0) ? 1 : 0;
      do_read(a, int'($urandom_range(0, 3)), mv[a[3:0]] && (mt[a[3:0]] == a[15:4]), memfn(a), fl);
    end

    // asynchronous reset in the middle of a refill
    wait_idle();
    mem_delay = 30; cpu_addr_i = 16'h0777; cpu_req_i = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_req", 32'(mem_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", 32'(mem_req_o), 32'd0);
    check("rst_mid_counts", {hit_cnt_o, miss_cnt_o}, 32'd0);
    cpu_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mhits = 0; mmiss = 0;
    check_flush_sweep("rst_mid");
    do_read(16'h0123, 1, 1'b0, 32'hDEADBEEF, 0);
    do_read(16'h0123, 0, 1'b1, 32'hDEADBEEF, 0);

    // saturation of the counter block
    sat_inc = 1'b1;
    repeat (65534) @(negedge clk);
    check("sat_fffe", 32'(sat_cnt), 32'h0000_FFFE);
    @(negedge clk);
    check("sat_ffff", 32'(sat_cnt), 32'h0000_FFFF);
    repeat (3) @(negedge clk);
    check("sat_hold", 32'(sat_cnt), 32'h0000_FFFF);
    sat_inc = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
